pointwise_div_seq: RTL and testbench
====================================

// Module: pointwise_div_seq
// PURPOSE
//  Streaming pointwise unsigned divider: out = in / divisor, rem = in % divisor.
//  Inverse stage of the multiply-by-constant pointwise kernel (DesignTop):
//   recovers the original pixel value from a scaled stream.
//  Restoring divider, one quotient bit per cycle.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  WIDTH    16  data width of dividend, divisor, quotient, remainder
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high reset
//  in_valid       in   1      input operands valid
//  in_ready       out  1      block can accept operands
//  in_arg_1_0_0   in   WIDTH  dividend (unsigned)
//  in_arg_2_0_0   in   WIDTH  divisor (unsigned)
//  out_valid      out  1      result valid; held until accepted
//  out_ready      in   1      downstream accepts result
//  out_0_0        out  WIDTH  quotient
//  out_rem_0_0    out  WIDTH  remainder
//  div_by_zero    out  1      result came from a zero divisor; same timing as out_0_0
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - state=IDLE; in_ready=1, out_valid=0.
//   - out_0_0, out_rem_0_0, div_by_zero=0.
//   - Reset overrides everything, including mid-BUSY or a pending DONE result.
//   - The in-flight operation is dropped and no result is emitted.
//  States:
//   - IDLE: in_ready=1. On in_valid&&in_ready:
//       latch dividend and divisor; clear partial remainder R; cnt=WIDTH-1; go to BUSY.
//   - BUSY: in_ready=0, out_valid=0. Each cycle:
//       R' = {R[WIDTH-1:0], dividend[cnt]}  (WIDTH+1 bits)
//       if R' >= divisor: R = R' - divisor, q[cnt]=1
//       else:             R = R',           q[cnt]=0
//       When cnt==0 and that step is done: go to DONE.
//   - DONE: out_valid=1; out_0_0=q, out_rem_0_0=R[WIDTH-1:0].
//       Outputs are stable while out_ready=0.
//       On out_valid&&out_ready: go to IDLE, out_valid=0.
//  Latency and throughput:
//   - Capture on edge k; the WIDTH iterations occupy edges k+1..k+WIDTH.
//   - out_valid is high after edge k+WIDTH.
//   - Best-case throughput is one result per WIDTH+2 cycles.
//   - in_ready is low in BUSY and DONE; no bypass from DONE to accept.
//  Divisor == 0:
//   - Skip BUSY; go straight to DONE on the edge after capture.
//   - out_0_0 = all ones; out_rem_0_0 = dividend; div_by_zero=1.
//  Other divisor cases:
//   - div_by_zero=0 for every nonzero divisor.
//   - divisor > dividend: q=0, rem=dividend (full WIDTH-cycle latency).
//  Arithmetic:
//   - Unsigned only.
//   - R is WIDTH+1 bits internally, so a divisor with MSB set works.
//   - Invariant: quotient*divisor + remainder == dividend, with remainder < divisor.
//  Handshake:
//   - in_valid may drop without being accepted; operands are sampled only on a handshake.
//   - out_valid never drops before out_ready is seen.
//   - Inputs presented while busy are ignored; the sender must hold them.
// TESTING
//  1. Reset, then dividend=0x0064, divisor=0x0002
//     -> after 16 cycles: q=0x0032, rem=0, dz=0.
//  2. dividend=0xFFFF, divisor=0x8001 -> q=0x0001, rem=0x7FFE (MSB-set divisor path).
//  3. dividend=0x1234, divisor=0
//     -> DONE one edge after capture: q=0xFFFF, rem=0x1234, dz=1.
//  4. out_ready low for 5 cycles in DONE, dividend=7, divisor=3
//     -> q=2, rem=1 held stable; in_ready stays 0 until accepted.
//  5. Assert reset at BUSY cycle 8, then release
//     -> out_valid stays 0, in_ready=1 next cycle, no stale result.
//  6. 1000 random pairs, random in_valid/out_ready stalls
//     -> q*d+rem==dividend and rem<d for every d!=0; no lost or duplicate results.

Source files
------------

// File: rtl/pointwise_div_seq.sv
// ---------------------------------------------------------------------------
// pointwise_div_seq
//   Streaming pointwise unsigned divider: quotient = dividend / divisor and
//   remainder = dividend % divisor. It is the inverse stage of the
//   multiply-by-constant pointwise kernel and recovers the original pixel
//   value from a scaled stream.
//   Restoring division, one quotient bit per clock, one operation in flight.
//
// Ports
//   clk            in   1      clock, rising edge
//   reset          in   1      synchronous, active-high reset
//   in_valid       in   1      operands valid
//   in_ready       out  1      block can accept operands (IDLE only)
//   in_arg_1_0_0   in   WIDTH  dividend (unsigned)
//   in_arg_2_0_0   in   WIDTH  divisor (unsigned)
//   out_valid      out  1      result valid, held until accepted
//   out_ready      in   1      downstream accepts result
//   out_0_0        out  WIDTH  quotient
//   out_rem_0_0    out  WIDTH  remainder
//   div_by_zero    out  1      result came from a zero divisor
//
// FSM states
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for operands, in_ready=1
//   S_BUSY | WIDTH restoring iterations, MSB of the dividend first
//   S_DONE | result presented on out_*, held until out_ready
// ---------------------------------------------------------------------------
module pointwise_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_arg_1_0_0,
  input  logic [WIDTH-1:0] in_arg_2_0_0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_0_0,
  output logic [WIDTH-1:0] out_rem_0_0,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [CW-1:0]    r_cnt;

  // Result registers are separate from the working registers so the
  // outputs only ever change on the BUSY->DONE (or zero-divisor) edge.
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_out_rem;
  logic             r_dz;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_zero_div = (in_arg_2_0_0 == '0);
  assign w_last     = (r_cnt == '0);

  // Partial remainder grows to WIDTH+1 bits before the compare so that a
  // divisor with its MSB set is still handled correctly.
  assign w_shift = {r_rem, r_dividend[r_cnt]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});

  // When w_ge holds the true difference is below the divisor and fits in
  // WIDTH bits, so a WIDTH-bit modular subtraction gives the exact result.
  assign w_sub      = w_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];

  always_comb begin
    w_quot_next        = r_quot;
    w_quot_next[r_cnt] = w_ge;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_zero_div ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_out_q    <= '0;
      r_out_rem  <= '0;
      r_dz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dividend <= in_arg_1_0_0;
            r_divisor  <= in_arg_2_0_0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= CW'(WIDTH - 1);
            if (w_zero_div) begin
              r_out_q   <= '1;
              r_out_rem <= in_arg_1_0_0;
              r_dz      <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt - 1'b1;
          if (w_last) begin
            r_out_q   <= w_quot_next;
            r_out_rem <= w_rem_next;
            r_dz      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_0_0     = r_out_q;
  assign out_rem_0_0 = r_out_rem;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_pointwise_div_seq.sv
module tb_pointwise_div_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] d_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         dz_out;

  int checks = 0;
  int errors = 0;

  pointwise_div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_arg_1_0_0 (a_in),
    .in_arg_2_0_0 (d_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_0_0      (q_out),
    .out_rem_0_0  (r_out),
    .div_by_zero  (dz_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair (DUT must be idle), then waits for out_valid.
  // lat = number of edges after the capture edge until out_valid is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] d,
                       output int lat, output bit timeout);
    in_valid = 1'b1;
    a_in     = a;
    d_in     = d;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    timeout  = 1'b0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    d_in      = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (q_out !== 16'h0000) begin errors++; $display("FAIL reset_q got %h want 0000", q_out); end
    checks++; if (r_out !== 16'h0000) begin errors++; $display("FAIL reset_rem got %h want 0000", r_out); end
    checks++; if (dz_out !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", dz_out); end
  endtask

  task automatic test_basic();
    int lat; bit to;
    do_op(16'h0064, 16'h0002, lat, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no out_valid want out_valid"); end
    checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
    checks++; if (q_out !== 16'h0032) begin errors++; $display("FAIL basic_q got %h want 0032", q_out); end
    checks++; if (r_out !== 16'h0000) begin errors++; $display("FAIL basic_rem got %h want 0000", r_out); end
    checks++; if (dz_out !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", dz_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    accept();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_msb_divisor();
    int lat; bit to;
    do_op(16'hFFFF, 16'h8001, lat, to);
    checks++; if (to || lat != 16) begin errors++; $display("FAIL msb_latency got %0d (timeout %0d) want 16", lat, to); end
    checks++; if (q_out !== 16'h0001) begin errors++; $display("FAIL msb_q got %h want 0001", q_out); end
    checks++; if (r_out !== 16'h7FFE) begin errors++; $display("FAIL msb_rem got %h want 7ffe", r_out); end
    checks++; if (dz_out !== 1'b0) begin errors++; $display("FAIL msb_dz got %b want 0", dz_out); end
    accept();
  endtask

  task automatic test_div_zero();
    int lat; bit to;
    do_op(16'h1234, 16'h0000, lat, to);
    checks++; if (to || lat != 0) begin errors++; $display("FAIL dz_latency got %0d (timeout %0d) want 0", lat, to); end
    checks++; if (q_out !== 16'hFFFF) begin errors++; $display("FAIL dz_q got %h want ffff", q_out); end
    checks++; if (r_out !== 16'h1234) begin errors++; $display("FAIL dz_rem got %h want 1234", r_out); end
    checks++; if (dz_out !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz_out); end
    accept();
  endtask

  task automatic test_divisor_gt();
    int lat; bit to;
    do_op(16'h0005, 16'h0009, lat, to);
    checks++; if (to || lat != 16) begin errors++; $display("FAIL gt_latency got %0d (timeout %0d) want 16", lat, to); end
    checks++; if (q_out !== 16'h0000 || r_out !== 16'h0005 || dz_out !== 1'b0) begin
      errors++; $display("FAIL gt_result got q=%h r=%h dz=%b want q=0000 r=0005 dz=0", q_out, r_out, dz_out);
    end
    accept();
  endtask

  task automatic test_out_stall();
    int lat; bit to;
    do_op(16'h0007, 16'h0003, lat, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got no out_valid want out_valid"); end
    // New operands offered while DONE must be ignored.
    in_valid = 1'b1;
    a_in     = 16'hAAAA;
    d_in     = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_out !== 16'h0002 || r_out !== 16'h0001 || dz_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b ready=%b q=%h r=%h dz=%b want valid=1 ready=0 q=0002 r=0001 dz=0",
                 i, out_valid, in_ready, q_out, r_out, dz_out);
      end
      tick();
    end
    in_valid = 1'b0;
    accept();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_no_capture got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    do_op(16'd1000, 16'd10, lat, to);
    checks++; if (to || q_out !== 16'd100 || r_out !== 16'd0) begin
      errors++; $display("FAIL b2b_first got q=%0d r=%0d timeout=%0d want q=100 r=0", q_out, r_out, to);
    end
    accept();
    do_op(16'd50000, 16'd7, lat, to);
    checks++; if (to || lat != 16) begin errors++; $display("FAIL b2b_latency got %0d (timeout %0d) want 16", lat, to); end
    checks++; if (q_out !== 16'd7142 || r_out !== 16'd6) begin
      errors++; $display("FAIL b2b_second got q=%0d r=%0d want q=7142 r=6", q_out, r_out);
    end
    accept();
  endtask

  task automatic test_reset_mid_busy();
    bit saw_valid;
    in_valid = 1'b1;
    a_in     = 16'h4321;
    d_in     = 16'h0003;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL busy_state got ready=%b valid=%b want ready=0 valid=0", in_ready, out_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_hs got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
    checks++; if (q_out !== 16'h0000 || r_out !== 16'h0000 || dz_out !== 1'b0) begin
      errors++; $display("FAIL midreset_out got q=%h r=%h dz=%b want 0000 0000 0", q_out, r_out, dz_out);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL midreset_stale got out_valid=1 want 0"); end
  endtask

  task automatic test_random();
    logic [W-1:0] qa[$];
    logic [W-1:0] qd[$];
    logic [W-1:0] ea, ed, eq, er, oq, orr, hq, hr;
    logic         edz, odz, hdz;
    bit           fire_in, fire_out, hold;
    int           sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      if (!in_valid) begin
        if (sent < 1000 && $urandom_range(2, 0) != 0) begin
          in_valid = 1'b1;
          a_in     = 16'($urandom);
          case ($urandom_range(7, 0))
            0:       d_in = 16'h0000;
            1:       d_in = 16'h8000 | 16'($urandom);
            2:       d_in = 16'($urandom_range(15, 1));
            default: d_in = 16'($urandom);
          endcase
        end
      end else if ($urandom_range(7, 0) == 0) begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(1, 0) == 1);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      hold     = out_valid && !out_ready;
      oq = q_out; orr = r_out; odz = dz_out;
      hq = q_out; hr = r_out; hdz = dz_out;
      ea = a_in; ed = d_in;
      tick();
      cyc++;
      if (fire_in) begin
        qa.push_back(ea);
        qd.push_back(ed);
        sent++;
        in_valid = 1'b0;
      end
      if (fire_out) begin
        got++;
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL rand_extra result q=%h r=%h with nothing outstanding", oq, orr);
        end else begin
          ea = qa.pop_front();
          ed = qd.pop_front();
          if (ed == '0) begin
            eq = 16'hFFFF; er = ea; edz = 1'b1;
          end else begin
            eq = ea / ed; er = ea % ed; edz = 1'b0;
          end
          if (oq !== eq || orr !== er || odz !== edz) begin
            errors++;
            $display("FAIL rand_result %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b", ea, ed, oq, orr, odz, eq, er, edz);
          end
          if (ed != '0) begin
            checks++;
            if ((32'(oq) * 32'(ed) + 32'(orr)) != 32'(ea) || orr >= ed) begin
              errors++; $display("FAIL rand_invariant %h/%h got q=%h r=%h", ea, ed, oq, orr);
            end
          end
        end
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || q_out !== hq || r_out !== hr || dz_out !== hdz) begin
          errors++;
          $display("FAIL rand_hold got valid=%b q=%h r=%h dz=%b want valid=1 q=%h r=%h dz=%b",
                   out_valid, q_out, r_out, dz_out, hq, hr, hdz);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 1000 || qa.size() != 0) begin
      errors++; $display("FAIL rand_count got results=%0d outstanding=%0d want 1000 and 0", got, qa.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_divisor();
    test_div_zero();
    test_divisor_gt();
    test_out_stall();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
